// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and AXI constants for the read-channel arbiter.
// State encoding, AXI burst/response codes and the latched request record.
package mem_read_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } rd_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
    } mem_read_req_t;

    // True when both byte addresses fall in the same cache line.
    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b,
                                       input int unsigned off);
        return (a >> off) == (b >> off);
    endfunction

endpackage

// File: rtl/mem_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping.
// Shared with the write engine, so it carries no state of its own.
module rr_arbiter #(
    parameter  int NUM_PORTS = 4,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!any_o && req_i[i] && (i >= int'(ptr_i))) begin
                any_o      = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IDX_W'(i);
            end
        end
        // Second pass covers the wrap: nothing at or above ptr_i was pending.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!any_o && req_i[i]) begin
                any_o      = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// AXI4 read front end: round-robin over NUM_PORTS requesters, one burst in flight.
// Define MEM_READ_RAW_CHECK_EN to hold back reads hitting the line being written.
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int NUM_PORTS        = 4,
    parameter int ID_WIDTH         = 4,
    parameter int LINE_BYTE_OFFSET = 6
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_PORTS-1:0]       i_req_valid,
    input  logic [NUM_PORTS-1:0][31:0] i_req_addr,
    input  logic [NUM_PORTS-1:0][3:0]  i_req_len,
    input  logic [NUM_PORTS-1:0][2:0]  i_req_size,
    output logic [NUM_PORTS-1:0]       o_req_ready,
    output logic [NUM_PORTS-1:0]       o_resp_valid,
    output logic [31:0]                o_resp_data,
    output logic                       o_resp_last,
    output logic                       o_resp_err,
    output logic                       o_proto_err,
    output logic                       o_idle,
    input  logic                       i_write_busy,
    input  logic [31:0]                i_write_addr,
    output logic [ID_WIDTH-1:0]        arid,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic                       arlock,
    output logic [3:0]                 arcache,
    output logic [2:0]                 arprot,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [ID_WIDTH-1:0]        rid,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    rd_state_e            state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    mem_read_req_t        req_q, req_d, sel_req;
    logic [3:0]           cnt_q, cnt_d;
    logic                 perr_q, perr_d;

    logic [NUM_PORTS-1:0] hazard_mask, eligible, arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any, beat;

`ifdef MEM_READ_RAW_CHECK_EN
    always_comb begin
        hazard_mask = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            hazard_mask[p] = i_write_busy &&
                             same_line(i_req_addr[p], i_write_addr, LINE_BYTE_OFFSET);
    end
`else
    // Write-side ports are kept for interface stability but have no effect here.
    localparam int unused_line_off = LINE_BYTE_OFFSET;
    logic unused_write;
    assign unused_write = ^{i_write_busy, i_write_addr};
    assign hazard_mask  = '0;
`endif

    assign eligible = i_req_valid & ~hazard_mask;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .req_i   (eligible),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    always_comb begin
        sel_req = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (arb_grant[p]) sel_req = '{addr: i_req_addr[p], len: i_req_len[p], size: i_req_size[p]};
    end

    assign beat = (state_q == ST_DATA) && rvalid;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        perr_d      = perr_q;
        o_req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_d = arb_idx;
                    req_d   = sel_req;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (arready) begin
                    o_req_ready = NUM_PORTS'(1) << grant_q;
                    cnt_d       = req_q.len;
                    rr_ptr_d    = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rvalid) begin
                    if (rid != ID_WIDTH'(grant_q)) perr_d = 1'b1;
                    if (rlast) begin
                        if (cnt_q != 4'd0) perr_d = 1'b1;
                        state_d = ST_IDLE;
                    end else if (cnt_q == 4'd0) begin
                        // Slave overran the burst; keep routing until it finally asserts rlast.
                        perr_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            req_q    <= '0;
            cnt_q    <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            req_q    <= req_d;
            cnt_q    <= cnt_d;
            perr_q   <= perr_d;
        end
    end

    assign arvalid = (state_q == ST_ADDR);
    assign arid    = ID_WIDTH'(grant_q);
    assign araddr  = req_q.addr;
    assign arlen   = {4'd0, req_q.len};
    assign arsize  = req_q.size;
    assign arburst = BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign rready  = (state_q == ST_DATA);

    assign o_resp_valid = beat ? (NUM_PORTS'(1) << grant_q) : '0;
    assign o_resp_data  = beat ? rdata : '0;
    assign o_resp_last  = beat && rlast;
    assign o_resp_err   = beat && (rresp != RESP_OKAY);
    assign o_proto_err  = perr_q;
    assign o_idle       = (state_q == ST_IDLE) && (i_req_valid == '0);

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Parametrised AXI4 read-channel front end for the memory subsystem that replaces the fixed two-source (instruction/data, cached/uncached) read muxing with NUM_PORTS independent requesters. The block arbitrates round-robin and issues one AR burst at a time, tagging each burst with the requester index. It routes R beats back to the granted requester and, optionally, holds back reads that hit a line still being written. It sits between the icache, dcache and uncached paths and the AXI read channels, alongside the write engine.

## Interface
- NUM_PORTS, 4, number of requesters (2..8)
- ID_WIDTH, 4, AXI ID width; must be ≥ $clog2(NUM_PORTS)
- LINE_BYTE_OFFSET, 6, log2 of cache-line bytes, used for hazard compare
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_req_valid  in  NUM_PORTS  per-port request; held until o_req_ready
- i_req_addr  in  NUM_PORTS×32  start byte address
- i_req_len  in  NUM_PORTS×4  AXI arlen (beats−1)
- i_req_size  in  NUM_PORTS×3  AXI arsize
- o_req_ready  out  NUM_PORTS  one-cycle pulse on AR handshake of that port's burst
- o_resp_valid  out  NUM_PORTS  one-hot; R beat for that port
- o_resp_data  out  32  shared beat data
- o_resp_last  out  1  final beat of burst
- o_resp_err  out  1  rresp≠OKAY on this beat
- o_proto_err  out  1  sticky: rlast/beat-count mismatch or rid≠granted id
- o_idle  out  1  IDLE and no i_req_valid
- i_write_busy  in  1  write engine has an in-flight burst
- i_write_addr  in  32  address of that burst
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  AXI AR
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  AXI R
- rready  out  1

## Operation
- FSM: IDLE → ADDR → DATA → IDLE.
- IDLE: eligible = i_req_valid & ~hazard_mask. If any is eligible, grant the first set bit at or after rr_ptr (wrap modulo NUM_PORTS). Latch index, addr, len and size. Go to ADDR.
- ADDR: arvalid=1 with latched fields; arid = zero-extended grant index; arburst=INCR (2'b01), arlock=0, arcache=4'b0000, arprot=0. On arvalid&arready: pulse o_req_ready[grant], load beat counter = len, rr_ptr ← grant+1 (wrap), go to DATA.
- DATA: rready=1. On each rvalid beat: o_resp_valid[grant]=1, o_resp_data=rdata, o_resp_last=rlast, o_resp_err=(rresp≠0). Counter decrements per beat.
  - rlast with counter=0 → IDLE.
  - rlast with counter≠0, or counter=0 without rlast → set o_proto_err; return to IDLE on rlast.
  - rid≠grant → set o_proto_err; beat still routed to grant.
- Only one outstanding burst; no AR issued while in DATA.
- Requester withdrawing valid before ready is illegal; the latched request still completes.

## Timing
- Reset: state IDLE, rr_ptr=0, o_proto_err=0. All other outputs are 0: arvalid, rready, o_req_ready, o_resp_valid, o_resp_data, o_resp_last, o_resp_err. o_idle=1 when no request is pending.
- Reset mid-burst aborts to IDLE; arvalid drops next edge (the system resets the interconnect together with this block).
- Request seen in IDLE at cycle 0 → arvalid at cycle 1 (registered AR outputs). With arready=1, o_req_ready pulses in cycle 1 and rready=1 from cycle 2.
- R path is combinational from rvalid/rdata to o_resp_*: zero-cycle latency, no buffering. Requesters must accept every beat.
- Back-to-back: the burst ending at cycle N returns to IDLE at N+1, and the next arvalid appears at N+2.
- Simultaneous requests: round-robin order only; no fixed priority.

## Configuration
- MEM_READ_RAW_CHECK_EN defined: in IDLE, port p is masked when i_write_busy is high and i_req_addr[p][31:LINE_BYTE_OFFSET] equals i_write_addr[31:LINE_BYTE_OFFSET]. Masked ports stay pending and other ports may be granted. The check applies only at grant time.
- Not defined: hazard_mask=0; i_write_busy and i_write_addr are ignored (ports remain for interface stability).

## Structure
- Shared package: FSM state enum, AXI constants (BURST_INCR, RESP_OKAY), and the mem_read_req-style request struct extended with len/size. The AXI AR/R typedefs stay in the existing package.
- Sub-module rr_arbiter (NUM_PORTS request vector + pointer → one-hot grant + index). It is purely combinational and reusable for the write engine.

## Test plan
- Single request: port 2, addr 0x1FC0_0040, len 15, arready=1 → arid=2, 16 beats routed to o_resp_valid[2], o_resp_last on beat 16, returns to IDLE, o_proto_err=0.
- Contention: ports 0, 1 and 3 valid together with rr_ptr=0 → grant order 0, 1, 3; then port 0 re-requesting with port 3 → grant 0 (rr_ptr=0 after 3).
- Back-pressure: arready low for 5 cycles → arvalid and araddr held stable, o_req_ready pulses only on the handshake cycle.
- Protocol error: len 3, rlast on beat 2 → o_proto_err=1 sticky, FSM back in IDLE; a following normal burst completes with o_proto_err still 1 until reset.
- RAW (macro on): i_write_busy=1 with write addr 0x0000_1000. Port 0 reads 0x0000_1020 and port 1 reads 0x0000_2000 → port 1 granted first. Port 0 is granted the cycle after i_write_busy falls. With the macro off, port 0 is granted first.
- Reset mid-DATA at beat 4 of 16 → next cycle IDLE, rready=0, o_resp_valid=0, rr_ptr=0.
